// File: rtl/jt6295_sh_rst_n.sv
`default_nettype none
// ============================================================================
//  Module   : jt6295_sh_rst_n
//  Purpose  : Clock-enabled delay line with asynchronous active-low clear.
//             WIDTH independent bit lanes, each STAGES flops deep. Used by the
//             ADPCM decoder to align pipeline side signals and to recirculate
//             per-voice state (STAGES=4 with four time-multiplexed voices
//             hands each voice its own previous result).
//  Ports    :
//    clk     in   1      system clock, rising edge
//    rst     in   1      asynchronous clear, active-low (0 = clear)
//    clk_en  in   1      shift enable
//    din     in   WIDTH  data into stage 0
//    drop    out  WIDTH  last stage, din delayed by STAGES enabled edges
//  Revision : 1.0 - initial release
// ============================================================================
module jt6295_sh_rst_n #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] drop
);

  // stage[k] holds the value captured k+1 enabled edges ago
  logic [WIDTH-1:0] stage [STAGES];

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] feed;

      // stage 0 takes the input, every later stage takes its predecessor
      if (k == 0) begin : g_head
        assign feed = din;
      end else begin : g_body
        assign feed = stage[k-1];
      end

      // A clock edge that coincides with reset release sees rst low and
      // keeps clearing, so the first capture is the first edge after release.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stage[k] <= '0;
        end else if (clk_en) begin
          stage[k] <= feed;
        end
      end
    end
  endgenerate

  // No output register: drop is the last stage itself.
  assign drop = stage[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_jt6295_sh_rst_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt6295_sh_rst_n
//  Purpose  : Self-checking bench for jt6295_sh_rst_n. Four instances:
//               a : WIDTH=12, STAGES=4   (reset, sequence, enable gating,
//                                         mid-stream reset)
//               b : WIDTH=1,  STAGES=1   (single-register corner)
//               c : WIDTH=5,  STAGES=32  (single pulse latency)
//               d : WIDTH=8,  STAGES=4   (recirculation din = drop + 1)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jt6295_sh_rst_n;

  typedef struct {
    logic        rst;
    logic        en;
    logic [11:0] din;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0, en_d = 1'b0;
  logic [11:0] din_a = '0;
  logic [0:0]  din_b = '0;
  logic [4:0]  din_c = '0;
  logic [11:0] drop_a;
  logic [0:0]  drop_b;
  logic [4:0]  drop_c;
  logic [7:0]  drop_d;
  logic [7:0]  din_d;

  int tests = 0;
  int fails = 0;

  vec_t vec_a[$];
  vec_t vec_b[$];

  assign din_d = drop_d + 8'd1;

  always #5 clk = ~clk;

  jt6295_sh_rst_n #(.WIDTH(12), .STAGES(4)) u_a (
    .clk(clk), .rst(rst), .clk_en(en_a), .din(din_a), .drop(drop_a));
  jt6295_sh_rst_n #(.WIDTH(1), .STAGES(1)) u_b (
    .clk(clk), .rst(rst), .clk_en(en_b), .din(din_b), .drop(drop_b));
  jt6295_sh_rst_n #(.WIDTH(5), .STAGES(32)) u_c (
    .clk(clk), .rst(rst), .clk_en(en_c), .din(din_c), .drop(drop_c));
  jt6295_sh_rst_n #(.WIDTH(8), .STAGES(4)) u_d (
    .clk(clk), .rst(rst), .clk_en(en_d), .din(din_d), .drop(drop_d));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // wait for the next rising edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [11:0] d,
                              input logic [11:0] x);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.exp = x;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- table for instance a ----------------
    vec_a.push_back(mk(0, 1, 12'hABC, 12'h000));
    vec_a.push_back(mk(0, 1, 12'hABC, 12'h000));
    vec_a.push_back(mk(1, 1, 12'hABC, 12'h000));
    vec_a.push_back(mk(1, 1, 12'hABC, 12'h000));
    vec_a.push_back(mk(1, 1, 12'hABC, 12'h000));
    vec_a.push_back(mk(1, 1, 12'hABC, 12'hABC));
    vec_a.push_back(mk(1, 1, 12'd1,   12'hABC));
    vec_a.push_back(mk(1, 1, 12'd2,   12'hABC));
    vec_a.push_back(mk(1, 1, 12'd3,   12'hABC));
    vec_a.push_back(mk(1, 1, 12'd4,   12'd1));
    vec_a.push_back(mk(1, 1, 12'd5,   12'd2));
    vec_a.push_back(mk(1, 1, 12'd6,   12'd3));
    vec_a.push_back(mk(1, 1, 12'd7,   12'd4));
    vec_a.push_back(mk(1, 1, 12'd8,   12'd5));
    vec_a.push_back(mk(1, 1, 12'd9,   12'd6));
    vec_a.push_back(mk(1, 1, 12'd10,  12'd7));
    for (int i = 0; i < 5; i++) vec_a.push_back(mk(1, 0, 12'd15, 12'd7));
    vec_a.push_back(mk(1, 1, 12'd0,   12'd8));
    vec_a.push_back(mk(1, 1, 12'd0,   12'd9));
    vec_a.push_back(mk(1, 1, 12'd0,   12'd10));
    vec_a.push_back(mk(1, 1, 12'd0,   12'd0));

    // ---------------- table for instance b (one stage) ----------------
    vec_b.push_back(mk(1, 1, 12'd1, 12'd1));
    vec_b.push_back(mk(1, 1, 12'd0, 12'd0));
    vec_b.push_back(mk(1, 1, 12'd1, 12'd1));
    vec_b.push_back(mk(1, 0, 12'd0, 12'd1));
    vec_b.push_back(mk(1, 0, 12'd0, 12'd1));
    vec_b.push_back(mk(1, 1, 12'd0, 12'd0));
    vec_b.push_back(mk(1, 1, 12'd1, 12'd1));
    vec_b.push_back(mk(1, 1, 12'd1, 12'd1));

    // ---------------- initial asynchronous reset ----------------
    #2 rst = 1'b0;
    #1;
    check("async_reset_a", 32'(drop_a), 32'd0);
    check("async_reset_c", 32'(drop_c), 32'd0);
    check("async_reset_d", 32'(drop_d), 32'd0);

    // ---------------- table a ----------------
    foreach (vec_a[i]) begin
      rst   = vec_a[i].rst;
      en_a  = vec_a[i].en;
      din_a = vec_a[i].din;
      tick();
      check($sformatf("vec_a[%0d]", i), 32'(drop_a), 32'(vec_a[i].exp));
    end
    en_a = 1'b0;

    // ---------------- table b ----------------
    foreach (vec_b[i]) begin
      rst   = vec_b[i].rst;
      en_b  = vec_b[i].en;
      din_b = vec_b[i].din[0:0];
      tick();
      check($sformatf("vec_b[%0d]", i), 32'(drop_b), 32'(vec_b[i].exp[0:0]));
    end
    en_b = 1'b0;

    // ---------------- mid-stream reset on a ----------------
    en_a = 1'b1;
    din_a = 12'h00F;
    for (int i = 0; i < 4; i++) tick();
    check("midrst_full", 32'(drop_a), 32'h00F);
    #3 rst = 1'b0;   // between clock edges
    #1;
    check("midrst_async_a", 32'(drop_a), 32'd0);
    check("midrst_async_b", 32'(drop_b), 32'd0);
    tick();
    check("midrst_held", 32'(drop_a), 32'd0);
    rst = 1'b1;
    din_a = 12'h003;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("midrst_release_e%0d", i), 32'(drop_a), (i == 4) ? 32'h003 : 32'd0);
    end
    en_a = 1'b0;

    // ---------------- 32-stage single pulse on c ----------------
    en_c = 1'b1;
    din_c = 5'h1F;
    for (int n = 1; n <= 34; n++) begin
      if (n == 10) begin
        // disabled clocks in mid-flight must not count toward the delay
        en_c = 1'b0;
        din_c = 5'h1F;
        for (int g = 0; g < 3; g++) begin
          tick();
          check("pulse_gap", 32'(drop_c), 32'd0);
        end
        en_c = 1'b1;
        din_c = 5'h00;
      end
      tick();
      check($sformatf("pulse_e%0d", n), 32'(drop_c), (n == 32) ? 32'h1F : 32'd0);
      din_c = 5'h00;
    end
    en_c = 1'b0;

    // ---------------- recirculation on d ----------------
    check("recirc_e0", 32'(drop_d), 32'd0);
    en_d = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      check($sformatf("recirc_e%0d", n), 32'(drop_d), 32'(n / 4));
    end
    en_d = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
